// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared stack frame definitions for the push sequencer and pop-side accumulator
package stack_pkg;

    localparam int WORD_W     = 16;
    localparam int FLAGS_W    = 3;
    localparam int PC_W       = 32;
    localparam int CALL_WORDS = 2;
    localparam int INT_WORDS  = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PUSH_FLAGS = 3'd1,
        ST_PUSH_HI    = 3'd2,
        ST_PUSH_LO    = 3'd3,
        ST_FINISH     = 3'd4
    } push_state_e;

    // Encoded in pop order: the pop side reads PC low first, flags last.
    typedef enum logic [1:0] {
        WSEL_PC_LO = 2'd0,
        WSEL_PC_HI = 2'd1,
        WSEL_FLAGS = 2'd2
    } word_sel_e;

    function automatic logic [WORD_W-1:0] frame_word(
        input word_sel_e           sel,
        input logic [PC_W-1:0]     pc,
        input logic [FLAGS_W-1:0]  flags
    );
        logic [WORD_W-1:0] w;
        case (sel)
            WSEL_PC_LO: w = pc[WORD_W-1:0];
            WSEL_PC_HI: w = pc[PC_W-1:WORD_W];
            WSEL_FLAGS: w = {{(WORD_W-FLAGS_W){1'b0}}, flags};
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/stack_push_sequencer.sv
// rtl/stack_push_sequencer.sv - pushes CALL/INT return frames onto the stack; optional STACK_OVF_CHECK_EN limit check
module stack_push_sequencer
    import stack_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SP_LIMIT = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               push_flags,
    input  logic [31:0]        pc_in,
    input  logic [2:0]         flags_in,
    input  logic [ADDR_W-1:0]  sp_in,
    input  logic               mem_ack,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [15:0]        mem_wdata,
    output logic               sp_we,
    output logic [ADDR_W-1:0]  sp_out,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    localparam logic [ADDR_W-1:0] SP_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    push_state_e          state, state_nx;
    word_sel_e            wsel;
    logic [PC_W-1:0]      pc_q;
    logic [FLAGS_W-1:0]   flags_q;
    logic [ADDR_W-1:0]    sp_cur;
    logic                 accept;
    logic                 word_done;

    assign accept    = (state == ST_IDLE) && start;
    assign word_done = mem_we && mem_ack;

`ifdef STACK_OVF_CHECK_EN
    // The frame needs n free words from sp_in downwards, so the lowest written
    // address sp_in-(n-1) must not fall below SP_LIMIT.
    logic [ADDR_W-1:0] frame_span;
    logic [ADDR_W-1:0] sp_floor;
    logic              ovf_hit;
    logic              ovf_q;

    assign frame_span = push_flags ? ADDR_W'(INT_WORDS - 1) : ADDR_W'(CALL_WORDS - 1);
    assign sp_floor   = SP_LIMIT + frame_span;
    assign ovf_hit    = sp_in < sp_floor;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= ovf_hit;
        end
    end
`else
    logic unused_sp_limit;
    assign unused_sp_limit = ^SP_LIMIT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc_q    <= '0;
            flags_q <= '0;
            sp_cur  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                pc_q    <= pc_in;
                flags_q <= flags_in;
                sp_cur  <= sp_in;
            end else if (word_done) begin
                sp_cur <= sp_cur - SP_STEP;
            end
        end
    end

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        wsel     = WSEL_PC_LO;
        sp_we    = 1'b0;
        done     = 1'b0;
        ovf      = 1'b0;
        busy     = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef STACK_OVF_CHECK_EN
                    if (ovf_hit)
                        state_nx = ST_FINISH;
                    else
`endif
                        state_nx = push_flags ? ST_PUSH_FLAGS : ST_PUSH_HI;
                end
            end
            ST_PUSH_FLAGS: begin
                mem_we = 1'b1;
                wsel   = WSEL_FLAGS;
                if (mem_ack) state_nx = ST_PUSH_HI;
            end
            ST_PUSH_HI: begin
                mem_we = 1'b1;
                wsel   = WSEL_PC_HI;
                if (mem_ack) state_nx = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                mem_we = 1'b1;
                wsel   = WSEL_PC_LO;
                if (mem_ack) state_nx = ST_FINISH;
            end
            ST_FINISH: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
`ifdef STACK_OVF_CHECK_EN
                sp_we = !ovf_q;
                ovf   = ovf_q;
`else
                sp_we = 1'b1;
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Address and SP buses stay at zero outside their strobes.
    assign mem_addr  = mem_we ? sp_cur : '0;
    assign mem_wdata = mem_we ? frame_word(wsel, pc_q, flags_q) : '0;
    assign sp_out    = sp_we ? sp_cur : '0;

endmodule

// File: tb/tb_stack_push_sequencer.sv
// tb/tb_stack_push_sequencer.sv - scoreboard bench for stack_push_sequencer
module tb_stack_push_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        push_flags;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic [31:0] sp_in;
    logic        mem_ack;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        sp_we;
    logic [31:0] sp_out;
    logic        busy;
    logic        done;
    logic        ovf;

    stack_push_sequencer #(.ADDR_W(32), .SP_LIMIT(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .start(start), .push_flags(push_flags),
        .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp_in), .mem_ack(mem_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sp_we(sp_we), .sp_out(sp_out), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fin;
        logic [31:0] addr;
        logic [15:0] data;
        bit          ovf;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [15:0] data);
        exp_t e;
        e.fin = 1'b0; e.addr = addr; e.data = data; e.ovf = 1'b0;
        q.push_back(e);
    endtask

    task automatic exp_fin(input logic [31:0] sp, input bit o);
        exp_t e;
        e.fin = 1'b1; e.addr = sp; e.data = '0; e.ovf = o;
        q.push_back(e);
    endtask

    logic        stall_prev;
    logic [31:0] addr_prev;
    logic [15:0] data_prev;

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_addr", mem_addr, addr_prev);
                check("hold_data", mem_wdata, data_prev);
            end
            if (mem_we && mem_ack) begin
                ok = (q.size() != 0) && !q[0].fin;
                check("write_expected", ok, 1);
                if (ok) begin
                    e = q.pop_front();
                    check("write_addr", mem_addr, e.addr);
                    check("write_data", mem_wdata, e.data);
                end
            end
            if (done || sp_we || ovf) begin
                ok = (q.size() != 0) && q[0].fin;
                check("finish_expected", ok, 1);
                if (ok) begin
                    e = q.pop_front();
                    check("done", done, 1);
                    check("sp_we", sp_we, !e.ovf);
                    check("ovf", ovf, e.ovf);
                    check("no_write_in_finish", mem_we, 0);
                    if (!e.ovf) check("sp_out", sp_out, e.addr);
                end
            end
            stall_prev <= mem_we && !mem_ack;
            addr_prev  <= mem_addr;
            data_prev  <= mem_wdata;
        end
    end

    task automatic run_frame(input bit is_int, input logic [31:0] pc, input logic [2:0] fl,
                             input logic [31:0] sp, input int stall_at, input int stall_n,
                             input int exp_done, input int poke_at, input int rst_at);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; push_flags = is_int; pc_in = pc; flags_in = fl; sp_in = sp; mem_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pc_in = '0; flags_in = '0; sp_in = '0;
        lat = 1;
        check("busy_after_start", busy, 1);
        while (1) begin
            mem_ack = !(lat >= stall_at && lat < stall_at + stall_n);
            start   = (lat == poke_at);
            if (lat == rst_at) begin
                mem_ack = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; mem_ack = 1'b1;
                check("rst_mem_we", mem_we, 0);
                check("rst_busy", busy, 0);
                check("rst_sp_we", sp_we, 0);
                check("rst_done", done, 0);
                return;
            end
            if (done) begin
                check("done_cycle", lat, exp_done);
                break;
            end
            if (lat > 40) begin
                check("done_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; mem_ack = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; push_flags = 1'b0; pc_in = '0; flags_in = '0; sp_in = '0; mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_sp_we", sp_we, 0);
        check("reset_sp_out", sp_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf", ovf, 0);
        rst = 1'b0;

        // CALL frame
        exp_wr(32'h0000_0FFF, 16'h0001);
        exp_wr(32'h0000_0FFE, 16'h2345);
        exp_fin(32'h0000_0FFD, 0);
        run_frame(0, 32'h0001_2345, 3'b000, 32'h0000_0FFF, 0, 0, 3, -1, -1);

        // INT frame
        exp_wr(32'h0000_0FFF, 16'h0005);
        exp_wr(32'h0000_0FFE, 16'hABCD);
        exp_wr(32'h0000_0FFD, 16'h0010);
        exp_fin(32'h0000_0FFC, 0);
        run_frame(1, 32'hABCD_0010, 3'b101, 32'h0000_0FFF, 0, 0, 4, -1, -1);

        // INT with two stalled cycles on the PC high write
        exp_wr(32'h0000_0800, 16'h0006);
        exp_wr(32'h0000_07FF, 16'h0F0F);
        exp_wr(32'h0000_07FE, 16'hF0F0);
        exp_fin(32'h0000_07FD, 0);
        run_frame(1, 32'h0F0F_F0F0, 3'b110, 32'h0000_0800, 2, 2, 6, -1, -1);

        // Reset while in PUSH_HI, then a normal frame
        exp_wr(32'h0000_0200, 16'h0003);
        run_frame(1, 32'h1234_5678, 3'b011, 32'h0000_0200, 0, 0, 0, -1, 2);
        exp_wr(32'h0000_0300, 16'hDEAD);
        exp_wr(32'h0000_02FF, 16'hBEEF);
        exp_fin(32'h0000_02FE, 0);
        run_frame(0, 32'hDEAD_BEEF, 3'b000, 32'h0000_0300, 0, 0, 3, -1, -1);

`ifndef STACK_OVF_CHECK_EN
        // SP wrap through zero, with a start poked while busy
        exp_wr(32'h0000_0000, 16'h8000);
        exp_wr(32'hFFFF_FFFF, 16'h7FFF);
        exp_fin(32'hFFFF_FFFE, 0);
        run_frame(0, 32'h8000_7FFF, 3'b000, 32'h0000_0000, 0, 0, 3, 1, -1);
`else
        exp_fin(32'h0000_0000, 1);
        run_frame(1, 32'h1111_2222, 3'b001, 32'h0000_0101, 0, 0, 1, -1, -1);
        exp_wr(32'h0000_0102, 16'h0001);
        exp_wr(32'h0000_0101, 16'h1111);
        exp_wr(32'h0000_0100, 16'h2222);
        exp_fin(32'h0000_00FF, 0);
        run_frame(1, 32'h1111_2222, 3'b001, 32'h0000_0102, 0, 0, 4, -1, -1);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        check("idle_busy", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/stack_push_sequencer.md
# stack_push_sequencer

Writes a CALL/INT return frame onto the data-memory stack, 16 bits at a time. It splits a 32-bit return PC, and optionally the 3-bit CCR flags, into 16-bit words and stores them at successive descending stack addresses. It then hands the updated SP back to the register file. It is the write-side counterpart of the pop-side accumulator that reassembles PC and flags on RET/RTI, and it pushes words in the exact reverse of the pop order.

## Interface
- `ADDR_W`, 32: stack pointer / memory address width.
- `SP_LIMIT`, 32'h0000_0000: lowest legal stack address. Used only when the overflow check is compiled in.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `push_flags` in 1: 1 = INT frame (flags + PC), 0 = CALL frame (PC only); sampled with `start`.
- `pc_in` in 32: return PC; captured on accepted `start`.
- `flags_in` in 3: CCR flags; captured on accepted `start`.
- `sp_in` in ADDR_W: current SP; captured on accepted `start`.
- `mem_ack` in 1: memory accepted the write this cycle.
- `mem_we` out 1: write strobe to data memory.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 16: write data.
- `sp_we` out 1: one-cycle SP writeback strobe.
- `sp_out` out ADDR_W: new SP value, valid while `sp_we` is high.
- `busy` out 1: frame in progress; the decode stage stalls on it.
- `done` out 1: one-cycle completion pulse.
- `ovf` out 1: one-cycle overflow-abort pulse; tied 0 unless the overflow check is compiled in.

## Operation
- States: IDLE, PUSH_FLAGS, PUSH_HI, PUSH_LO, FINISH.
- IDLE:
  - `start`=1 captures `pc_in`, `flags_in`, `sp_in` into `sp_cur`.
  - With `push_flags`=1 the next state is PUSH_FLAGS; otherwise PUSH_HI.
- Word order and data:
  - PUSH_FLAGS writes {13'b0, flags}.
  - PUSH_HI writes pc[31:16].
  - PUSH_LO writes pc[15:0].
  - Popping therefore yields PC low, PC high, then flags.
- Each PUSH state:
  - `mem_we`=1, `mem_addr`=`sp_cur`, `mem_wdata` as above.
  - On `mem_ack`=1: `sp_cur` <= `sp_cur`−1 and advance (PUSH_FLAGS→PUSH_HI→PUSH_LO→FINISH).
  - On `mem_ack`=0: hold state, address and data unchanged.
- SP addressing is post-decrement: the word at SP is written, then SP moves down.
- FINISH: `sp_we`=1, `sp_out`=`sp_cur`, `done`=1, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored; there is no queueing.
- SP arithmetic is modulo 2^ADDR_W; 0 − 1 wraps to all-ones.
- Reset:
  - All outputs are 0, including `sp_out` and `mem_addr`; state is IDLE.
  - `rst` mid-frame aborts immediately. No further writes occur and there is no `sp_we`. Words already written stay in memory.

## Timing
- `start` is accepted at edge 0.
- With `mem_ack` tied 1:
  - CALL: writes in cycles 1–2, `done`/`sp_we` in cycle 3.
  - INT: writes in cycles 1–3, `done`/`sp_we` in cycle 4.
- Each cycle of `mem_ack`=0 adds exactly one cycle.
- The earliest next `start` acceptance is the cycle after `done`.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from `start` to `mem_we`.

## Configuration
- `STACK_OVF_CHECK_EN` defined:
  - On accepted `start`, let n = 3 (INT) or 2 (CALL).
  - If `sp_in` < `SP_LIMIT` + n − 1 (unsigned), go directly to FINISH. In FINISH: `ovf`=1, `done`=1, `sp_we`=0, and no memory writes occur.
- `STACK_OVF_CHECK_EN` undefined: `ovf` is constant 0, there is no compare logic, and SP wraps freely.

## Structure
- Shared `stack_pkg` holds:
  - the state enum;
  - WORD_W=16 and FLAGS_W=3;
  - frame lengths CALL_WORDS=2 and INT_WORDS=3;
  - the word-order encoding shared with the pop-side accumulator.
- The block is a single module with no sub-module. The limit comparator is a few lines under the macro.

## Test plan
- CALL, `pc_in`=32'h0001_2345, `sp_in`=32'h0000_0FFF, ack=1 → writes [0FFF]=0001, [0FFE]=2345; `sp_out`=0FFD with `done` in cycle 3.
- INT, `flags_in`=3'b101, `pc_in`=32'hABCD_0010, `sp_in`=0FFF → writes [0FFF]=0005, [0FFE]=ABCD, [0FFD]=0010; `sp_out`=0FFC with `done` in cycle 4.
- INT with `mem_ack` low for 2 cycles on the PUSH_HI write → `mem_addr`/`mem_wdata` held stable; `done` in cycle 6.
- `rst` asserted in PUSH_HI → next cycle `mem_we`=0, `busy`=0, no `sp_we`; a new `start` is accepted normally.
- `sp_in`=0, CALL, macro off → writes [0]=hi, [FFFF_FFFF]=lo; `sp_out`=FFFF_FFFE. `start` during busy produces no extra writes.
- Macro on, `SP_LIMIT`=32'h100, INT with `sp_in`=32'h101 → `ovf`=1, `done`=1, zero writes, `sp_we`=0. With `sp_in`=32'h102 → normal 3-word frame.
